// File: rtl/seg7_capture_decoder_if.sv
// Display-bus and frame-handshake bundle between a 7-segment multiplexed driver/consumer
// and the capture decoder.
interface seg7_capture_decoder_if #(
  parameter int NDIG = 4
);
  logic [6:0]        segment7;
  logic [NDIG-1:0]   digit_sel;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   err_out;
  logic              frame_valid;
  logic              frame_ready;
  logic              overflow;

  modport master (
    output segment7, digit_sel, frame_ready,
    input  bcd_out, err_out, frame_valid, overflow
  );

  modport slave (
    input  segment7, digit_sel, frame_ready,
    output bcd_out, err_out, frame_valid, overflow
  );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Recovers BCD digits from a time-multiplexed 7-segment bus ({a..g}, active-high) and
// presents each complete frame on a valid/ready output with per-digit illegal flags.
module seg7_capture_decoder #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    reset_n,
  seg7_capture_decoder_if.slave  bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b1111110: return {1'b0, 4'd0};
      7'b0110000: return {1'b0, 4'd1};
      7'b1101101: return {1'b0, 4'd2};
      7'b1111001: return {1'b0, 4'd3};
      7'b0110011: return {1'b0, 4'd4};
      7'b1011011: return {1'b0, 4'd5};
      7'b1011111: return {1'b0, 4'd6};
      7'b1110000: return {1'b0, 4'd7};
      7'b1111111: return {1'b0, 4'd8};
      7'b1110011: return {1'b0, 4'd9};
      default:    return {1'b1, 4'hF};
    endcase
  endfunction

  function automatic logic onehot_ok(input logic [NDIG-1:0] sel);
    return (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
  endfunction

  function automatic logic [IW-1:0] sel_index(input logic [NDIG-1:0] sel);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (sel[k]) idx = idx | IW'(k);
    end
    return idx;
  endfunction

  logic [6:0]            s_seg_q, s_seg_d;
  logic [NDIG-1:0]       s_sel_q, s_sel_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  cap_vld_q, cap_vld_d;
  logic [IW-1:0]         cap_idx_q, cap_idx_d;
  logic [6:0]            cap_seg_q, cap_seg_d;
  logic [NDIG-1:0][3:0]  slot_val_q, slot_val_d;
  logic [NDIG-1:0]       slot_err_q, slot_err_d;
  logic [NDIG-1:0]       seen_q, seen_d;
  logic [NDIG-1:0][3:0]  bcd_q, bcd_d;
  logic [NDIG-1:0]       err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  logic                  sel_ok_s, same_s, complete_s, load_s, drop_s;
  logic [4:0]            dec_s;

  // Next-state: sampling, run counting, capture, slot write and frame hand-off
  always_comb begin
    s_seg_d    = bus.segment7;
    s_sel_d    = bus.digit_sel;
    sel_ok_s   = onehot_ok(bus.digit_sel);
    same_s     = (bus.segment7 == s_seg_q) && (bus.digit_sel == s_sel_q);

    if (!sel_ok_s) begin
      count_d = '0;
    end else if (same_s) begin
      count_d = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
    end else begin
      count_d = CW'(1);
    end

    // A saturated run that simply continues must not capture again
    cap_vld_d  = sel_ok_s && (count_d == CNT_MAX) && !(same_s && (count_q == CNT_MAX));
    cap_idx_d  = sel_index(bus.digit_sel);
    cap_seg_d  = bus.segment7;

    dec_s      = decode_seg(cap_seg_q);
    complete_s = &seen_q;
    slot_val_d = slot_val_q;
    slot_err_d = slot_err_q;
    seen_d     = complete_s ? '0 : seen_q;
    if (cap_vld_q) begin
      slot_val_d[cap_idx_q] = dec_s[3:0];
      slot_err_d[cap_idx_q] = dec_s[4];
      seen_d[cap_idx_q]     = 1'b1;
    end else begin
      seen_d = seen_d;
    end

    load_s = complete_s && (!valid_q || bus.frame_ready);
    drop_s = complete_s && valid_q && !bus.frame_ready;
    ovf_d  = ovf_q | drop_s;
    if (load_s) begin
      bcd_d   = slot_val_q;
      err_d   = slot_err_q;
      valid_d = 1'b1;
    end else if (valid_q && bus.frame_ready) begin
      bcd_d   = bcd_q;
      err_d   = err_q;
      valid_d = 1'b0;
    end else begin
      bcd_d   = bcd_q;
      err_d   = err_q;
      valid_d = valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_seg_q    <= 7'd0;
      s_sel_q    <= '0;
      count_q    <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      cap_seg_q  <= 7'd0;
      slot_val_q <= '0;
      slot_err_q <= '0;
      seen_q     <= '0;
      bcd_q      <= '0;
      err_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s_seg_q    <= s_seg_d;
      s_sel_q    <= s_sel_d;
      count_q    <= count_d;
      cap_vld_q  <= cap_vld_d;
      cap_idx_q  <= cap_idx_d;
      cap_seg_q  <= cap_seg_d;
      slot_val_q <= slot_val_d;
      slot_err_q <= slot_err_d;
      seen_q     <= seen_d;
      bcd_q      <= bcd_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.err_out     = err_q;
  assign bus.frame_valid = valid_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder (NDIG=4, STABLE_CYCLES=4) with hand-computed
// expected frames.
module tb_seg7_capture_decoder;
  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  seg7_capture_decoder_if #(.NDIG(4)) bus ();

  seg7_capture_decoder #(.NDIG(4), .STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [6:0] seg, input logic [3:0] sel, input int n);
    for (int i = 0; i < n; i++) begin
      bus.segment7  = seg;
      bus.digit_sel = sel;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    hold(7'd0, 4'd0, n);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n         = 1'b0;
    bus.segment7    = 7'd0;
    bus.digit_sel   = 4'd0;
    bus.frame_ready = 1'b0;
    #12;
    chk("reset_bcd", 32'(bus.bcd_out), 32'h0);
    chk("reset_err", 32'(bus.err_out), 32'h0);
    chk("reset_valid", 32'(bus.frame_valid), 32'h0);
    chk("reset_ovf", 32'(bus.overflow), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Legal decode 1,2,3,4 with ready high
    bus.frame_ready = 1'b1;
    hold(7'b0110000, 4'b0001, 6);
    hold(7'b1101101, 4'b0010, 6);
    hold(7'b1111001, 4'b0100, 6);
    hold(7'b0110011, 4'b1000, 4);
    chk("legal_valid_E3", 32'(bus.frame_valid), 32'h0);
    hold(7'b0110011, 4'b1000, 1);
    chk("legal_valid_E4", 32'(bus.frame_valid), 32'h0);
    hold(7'b0110011, 4'b1000, 1);
    chk("legal_valid_E5", 32'(bus.frame_valid), 32'h1);
    chk("legal_bcd", 32'(bus.bcd_out), 32'h4321);
    chk("legal_err", 32'(bus.err_out), 32'h0);
    idle(1);
    chk("legal_valid_drop", 32'(bus.frame_valid), 32'h0);
    bus.frame_ready = 1'b0;

    // Stability filter: short run of '1' never captured
    hold(7'b0110000, 4'b0001, 3);
    hold(7'b1111110, 4'b0001, 4);
    hold(7'b1011011, 4'b0010, 4);
    hold(7'b1011111, 4'b0100, 4);
    hold(7'b1110000, 4'b1000, 4);
    idle(2);
    chk("stable_valid", 32'(bus.frame_valid), 32'h1);
    chk("stable_bcd", 32'(bus.bcd_out), 32'h7650);
    bus.frame_ready = 1'b1;
    idle(1);
    bus.frame_ready = 1'b0;
    chk("stable_consume", 32'(bus.frame_valid), 32'h0);

    // Illegal pattern on digit 2
    hold(7'b1110000, 4'b0001, 4);
    hold(7'b1111111, 4'b0010, 4);
    hold(7'b0000001, 4'b0100, 4);
    hold(7'b1110011, 4'b1000, 4);
    idle(2);
    chk("illegal_valid", 32'(bus.frame_valid), 32'h1);
    chk("illegal_bcd", 32'(bus.bcd_out), 32'h9F87);
    chk("illegal_err", 32'(bus.err_out), 32'h4);
    bus.frame_ready = 1'b1;
    idle(1);
    bus.frame_ready = 1'b0;
    chk("illegal_consume", 32'(bus.frame_valid), 32'h0);

    // Backpressure: second frame dropped, first held
    hold(7'b0110000, 4'b0001, 4);
    hold(7'b1101101, 4'b0010, 4);
    hold(7'b1111001, 4'b0100, 4);
    hold(7'b0110011, 4'b1000, 4);
    idle(2);
    chk("bp_first_valid", 32'(bus.frame_valid), 32'h1);
    chk("bp_first_bcd", 32'(bus.bcd_out), 32'h4321);
    chk("bp_first_ovf", 32'(bus.overflow), 32'h0);
    hold(7'b1011011, 4'b0001, 4);
    hold(7'b1011111, 4'b0010, 4);
    hold(7'b1110000, 4'b0100, 4);
    hold(7'b1111111, 4'b1000, 4);
    idle(2);
    chk("bp_held_bcd", 32'(bus.bcd_out), 32'h4321);
    chk("bp_held_valid", 32'(bus.frame_valid), 32'h1);
    chk("bp_ovf", 32'(bus.overflow), 32'h1);
    bus.frame_ready = 1'b1;
    idle(1);
    bus.frame_ready = 1'b0;
    chk("bp_consume", 32'(bus.frame_valid), 32'h0);
    idle(1);
    chk("bp_ovf_sticky", 32'(bus.overflow), 32'h1);

    // Simultaneous consume and load after a fresh reset
    reset_n = 1'b0;
    #1;
    chk("rst2_ovf", 32'(bus.overflow), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    hold(7'b1111110, 4'b0001, 4);
    hold(7'b0110000, 4'b0010, 4);
    hold(7'b1101101, 4'b0100, 4);
    hold(7'b1111001, 4'b1000, 4);
    idle(2);
    chk("sim_first_bcd", 32'(bus.bcd_out), 32'h3210);
    hold(7'b0110011, 4'b0001, 4);
    hold(7'b1011011, 4'b0010, 4);
    hold(7'b1011111, 4'b0100, 4);
    hold(7'b1110000, 4'b1000, 4);
    idle(1);
    chk("sim_pre_bcd", 32'(bus.bcd_out), 32'h3210);
    bus.frame_ready = 1'b1;
    idle(1);
    chk("sim_valid", 32'(bus.frame_valid), 32'h1);
    chk("sim_bcd", 32'(bus.bcd_out), 32'h7654);
    chk("sim_ovf", 32'(bus.overflow), 32'h0);
    idle(1);
    bus.frame_ready = 1'b0;
    chk("sim_consume", 32'(bus.frame_valid), 32'h0);

    // Async reset mid-frame with a held frame on the output
    hold(7'b1110011, 4'b0001, 4);
    hold(7'b1110011, 4'b0010, 4);
    hold(7'b1110011, 4'b0100, 4);
    hold(7'b1110011, 4'b1000, 4);
    idle(2);
    chk("mid_held_bcd", 32'(bus.bcd_out), 32'h9999);
    hold(7'b0110000, 4'b0001, 4);
    hold(7'b1101101, 4'b0010, 4);
    idle(1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(bus.bcd_out), 32'h0);
    chk("mid_rst_valid", 32'(bus.frame_valid), 32'h0);
    chk("mid_rst_err", 32'(bus.err_out), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    hold(7'b1111001, 4'b0100, 4);
    hold(7'b0110011, 4'b1000, 4);
    idle(3);
    chk("mid_partial_valid", 32'(bus.frame_valid), 32'h0);
    hold(7'b1011011, 4'b0001, 4);
    hold(7'b1011111, 4'b0010, 4);
    idle(2);
    chk("mid_full_valid", 32'(bus.frame_valid), 32'h1);
    chk("mid_full_bcd", 32'(bus.bcd_out), 32'h4365);
    chk("mid_full_ovf", 32'(bus.overflow), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
